// File: rtl/maze_pg_if.sv
// Power-gating control bundle between the mesh-side requester (master) and
// maze_pg_ctrl (slave).
//   pg_req / pg_req_node : gate request and target node {vp[2:0], hp[2:0]}
//   pg_rel               : release request for the gated node
//   net_busy             : OR of all in-flight mesh valids
//   pg_en / pg_node      : clock gate enable and latched target node
//   inj_hold             : mesh-wide block on new A-port injection
//   node_rst_n           : active-low reset for node pg_node
//   pg_busy / pg_done    : sequencer busy, completion pulse
//   err_tmo              : sticky, last gate was forced by drain timeout
interface maze_pg_if #(
  parameter int unsigned ID_W = 6
) ();
  logic            pg_req;
  logic [ID_W-1:0] pg_req_node;
  logic            pg_rel;
  logic            net_busy;
  logic            pg_en;
  logic [ID_W-1:0] pg_node;
  logic            inj_hold;
  logic            node_rst_n;
  logic            pg_busy;
  logic            pg_done;
  logic            err_tmo;

  modport master (
    output pg_req, pg_req_node, pg_rel, net_busy,
    input  pg_en, pg_node, inj_hold, node_rst_n, pg_busy, pg_done, err_tmo
  );

  modport slave (
    input  pg_req, pg_req_node, pg_rel, net_busy,
    output pg_en, pg_node, inj_hold, node_rst_n, pg_busy, pg_done, err_tmo
  );
endinterface

// File: rtl/maze_pg_ctrl.sv
// Power-gating sequencer for one node of the 8x8 MAZE mesh.
// Gate request -> hold injection mesh-wide, wait for the mesh to drain
// (or time out), then gate the node's clock. Release -> ungate, hold the
// node in reset for RST_HOLD cycles, then resume injection.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pg         : maze_pg_if slave modport (requests in, gating controls out)
// All outputs are registered.
module maze_pg_ctrl #(
  parameter int unsigned ID_W      = 6,
  parameter int unsigned DRAIN_CYC = 16,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  maze_pg_if.slave pg
);

  localparam int unsigned IdleW = $clog2(DRAIN_CYC + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam int unsigned RstW  = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StQuiesce, StGated, StWake} state_e;

  state_e          state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [ID_W-1:0]  pg_node_q, pg_node_d;
  logic            pg_en_q, pg_en_d;
  logic            inj_hold_q, inj_hold_d;
  logic            node_rst_n_q, node_rst_n_d;
  logic            pg_busy_q, pg_busy_d;
  logic            pg_done_q, pg_done_d;
  logic            err_tmo_q, err_tmo_d;

  logic drain_ok, tmo_hit;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    pg_node_d  = pg_node_q;
    err_tmo_d  = err_tmo_q;
    pg_done_d  = 1'b0;

    // Exit conditions evaluated against the current-cycle counter values.
    drain_ok = !pg.net_busy && (idle_cnt_q == IdleW'(DRAIN_CYC - 1));
    tmo_hit  = (tmo_cnt_q == TmoW'(TIMEOUT - 1));

    unique case (state_q)
      StIdle: begin
        // pg_rel is not looked at here, so a simultaneous request wins.
        if (pg.pg_req) begin
          pg_node_d  = pg.pg_req_node;
          err_tmo_d  = 1'b0;
          idle_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = StQuiesce;
        end
      end
      StQuiesce: begin
        if (pg.net_busy) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IdleW'(DRAIN_CYC)) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (tmo_cnt_q != TmoW'(TIMEOUT)) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        // A clean drain takes priority so err_tmo only flags a real force.
        if (drain_ok) begin
          state_d   = StGated;
          pg_done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d   = StGated;
          err_tmo_d = 1'b1;
          pg_done_d = 1'b1;
        end
      end
      StGated: begin
        if (pg.pg_rel) begin
          rst_cnt_d = '0;
          state_d   = StWake;
        end
      end
      StWake: begin
        if (rst_cnt_q != RstW'(RST_HOLD)) begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
        if (rst_cnt_q == RstW'(RST_HOLD - 1)) begin
          state_d   = StIdle;
          pg_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they change with it.
    pg_en_d      = (state_d == StGated);
    inj_hold_d   = (state_d == StQuiesce) || (state_d == StWake);
    node_rst_n_d = (state_d != StWake);
    pg_busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idle_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      pg_node_q    <= '0;
      pg_en_q      <= 1'b0;
      inj_hold_q   <= 1'b0;
      node_rst_n_q <= 1'b1;
      pg_busy_q    <= 1'b0;
      pg_done_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      pg_node_q    <= pg_node_d;
      pg_en_q      <= pg_en_d;
      inj_hold_q   <= inj_hold_d;
      node_rst_n_q <= node_rst_n_d;
      pg_busy_q    <= pg_busy_d;
      pg_done_q    <= pg_done_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign pg.pg_en      = pg_en_q;
  assign pg.pg_node    = pg_node_q;
  assign pg.inj_hold   = inj_hold_q;
  assign pg.node_rst_n = node_rst_n_q;
  assign pg.pg_busy    = pg_busy_q;
  assign pg.pg_done    = pg_done_q;
  assign pg.err_tmo    = err_tmo_q;

endmodule

// File: doc/maze_pg_ctrl.md
Name: maze_pg_ctrl

Overview:
- Sequencer for the mesh fault/power-gating controls `pg_en` and `pg_node` that feed the 8x8 MAZE node array.
- Accepts a gate request for one node and blocks new A-port injection mesh-wide.
- Waits for the mesh to drain, then applies the clock gate. On release it ungates the node, holds it in reset, and resumes injection.
- Sits beside the mesh top; its outputs drive the per-node clock gating and the injection-hold logic.

Parameters:
- ID_W, 6, node coordinate width {vp[2:0], hp[2:0]}.
- DRAIN_CYC, 16, consecutive mesh-idle cycles required before gating; must be >= 1.
- TIMEOUT, 1024, maximum cycles spent in QUIESCE before forced gating; must be > DRAIN_CYC.
- RST_HOLD, 4, cycles the woken node is held in reset; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pg_req  in  1  single-cycle gate request, sampled only in IDLE.
- pg_req_node  in  ID_W  coordinate of the node to gate, latched with pg_req.
- pg_rel  in  1  single-cycle release request, sampled only in GATED.
- net_busy  in  1  OR of all in-flight valids (A/B/C ports, IRS stages).
- pg_en  out  1  gate active; the node equal to pg_node has its clock forced low.
- pg_node  out  ID_W  latched target coordinate.
- inj_hold  out  1  blocks acceptance of new pkt_in at every node.
- node_rst_n  out  1  active-low reset for node pg_node; the top ANDs it with rst_n for that node only.
- pg_busy  out  1  high whenever state != IDLE.
- pg_done  out  1  one-cycle pulse on entry to GATED and on return to IDLE from WAKE.
- err_tmo  out  1  sticky flag: the last gate was forced by timeout.

Behaviour:
- Clock and reset: single clock `clk`; reset is asynchronous and active-low (`rst_n`).
- Outputs: all outputs are registered.
- Reset values: state=IDLE, pg_en=0, pg_node=0, inj_hold=0, node_rst_n=1, pg_busy=0, pg_done=0, err_tmo=0, counters=0.
- Reset mid-operation: any state returns to IDLE immediately and asynchronously; pg_en drops without a WAKE sequence.
- Counters: idle_cnt, width $clog2(DRAIN_CYC+1); tmo_cnt, width $clog2(TIMEOUT+1); rst_cnt, width $clog2(RST_HOLD+1). All saturate and never wrap.

States:
- IDLE:
  - pg_req=1: latch pg_req_node into pg_node, clear err_tmo, go to QUIESCE.
  - pg_rel is ignored, including when it arrives in the same cycle as pg_req (the request wins).
- QUIESCE (inj_hold=1, pg_en=0):
  - idle_cnt increments on each cycle with net_busy=0 and clears to 0 on net_busy=1.
  - tmo_cnt increments every cycle.
  - Normal exit: net_busy=0 with idle_cnt==DRAIN_CYC-1 goes to GATED.
  - Timeout exit: otherwise, tmo_cnt==TIMEOUT-1 goes to GATED and sets err_tmo.
  - If both exit conditions hold in the same cycle, err_tmo stays 0.
- GATED (pg_en=1, inj_hold=0):
  - pg_done pulses in the first GATED cycle.
  - pg_req is ignored.
  - pg_rel=1 goes to WAKE.
- WAKE (pg_en=0, node_rst_n=0, inj_hold=1):
  - Lasts exactly RST_HOLD cycles, counted by rst_cnt.
  - Then goes to IDLE; node_rst_n=1, inj_hold=0 and pg_done=1 for one cycle.
- Requests ignored outside their sampling state are dropped; they are not queued.
- pg_node holds its value after release until the next accepted pg_req.

Latency (net_busy=0 throughout):
- pg_req sampled at edge 0: inj_hold=1 and pg_busy=1 after edge 0.
- pg_en=1 after edge DRAIN_CYC.
- pg_rel sampled at edge k: pg_en=0 and node_rst_n=0 after edge k; node_rst_n=1 after edge k+RST_HOLD.

Test Plan:
- Clean gate: net_busy=0, pg_req with node=6'h1B, defaults -> inj_hold=1 after edge 0; pg_en=1, pg_node=6'h1B and pg_done pulse after edge 16; err_tmo=0.
- Busy during drain: net_busy=1 for cycles 1-10, then 0 -> idle_cnt restarts; pg_en rises 16 cycles after net_busy falls; inj_hold stays 1 throughout QUIESCE.
- Timeout: net_busy stuck at 1 -> pg_en=1 after 1024 QUIESCE cycles; err_tmo=1; a following accepted pg_req clears err_tmo.
- Release: pg_rel in GATED -> pg_en=0 and node_rst_n=0 for exactly 4 cycles with inj_hold=1; then inj_hold=0 and pg_done pulses once; pg_node is still 6'h1B.
- Ignored requests: pg_req in GATED with node=6'h05 -> pg_node is unchanged; pg_rel in IDLE/QUIESCE has no effect; simultaneous pg_req and pg_rel in IDLE -> QUIESCE.
- Async reset mid-QUIESCE and mid-GATED: pulsing rst_n low -> pg_en, inj_hold and pg_busy drop to 0 and node_rst_n goes to 1 without waiting for a clock edge; state is IDLE after reset.
